// File: rtl/addsub_acc_if.sv
// addsub_acc_if
//   Bundles the command handshake, the external adder connection and the
//   result handshake of addsub_acc_ctrl. Signal names keep the block's
//   _i/_o suffixes as seen from the controller.
//   slave  : controller side (addsub_acc_ctrl)
//   master : environment side (command source, adder, result sink)
// Signals
//   in_valid_i/in_ready_o    command handshake
//   op_i[1:0], data_i        command opcode and operand
//   a_o, b_o, add_sub_o      adder operands and subtract select
//   sum_i, carry_i, ovf_i    adder result, carry-out, signed overflow
//   out_valid_o/out_ready_i  result handshake
//   acc_o, carry_o, ovf_o, zero_o, neg_o, sticky_ovf_o  result and flags
interface addsub_acc_if #(
  parameter int WIDTH = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic             add_sub_o;
  logic [WIDTH-1:0] sum_i;
  logic             carry_i;
  logic             ovf_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] acc_o;
  logic             carry_o;
  logic             ovf_o;
  logic             zero_o;
  logic             neg_o;
  logic             sticky_ovf_o;

  modport slave (
    input  in_valid_i, op_i, data_i, sum_i, carry_i, ovf_i, out_ready_i,
    output in_ready_o, a_o, b_o, add_sub_o, out_valid_o,
           acc_o, carry_o, ovf_o, zero_o, neg_o, sticky_ovf_o
  );

  modport master (
    output in_valid_i, op_i, data_i, sum_i, carry_i, ovf_i, out_ready_i,
    input  in_ready_o, a_o, b_o, add_sub_o, out_valid_o,
           acc_o, carry_o, ovf_o, zero_o, neg_o, sticky_ovf_o
  );
endinterface

// File: rtl/addsub_acc_ctrl.sv
// addsub_acc_ctrl
//   Sequencer and accumulator around an external WIDTH-bit add/subtract
//   datapath. Accepts one LOAD/ADD/SUB/CLR command at a time, drives the
//   adder with (accumulator, operand), registers the result and flags, and
//   holds them on a valid/ready output handshake.
// Ports
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    addsub_acc_if.slave (command, adder and result signals)
// Build option
//   SATURATE_EN  when defined, an overflowing ADD/SUB loads the signed
//                saturation limit instead of the wrapped sum.
module addsub_acc_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  addsub_acc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;

`ifdef SATURATE_EN
  // A wrapped sum with the sign bit set means the true result overflowed
  // positive, so clamp to the largest positive value (and vice versa).
  function automatic logic signed [WIDTH-1:0] sat_value(input logic [WIDTH-1:0] sum);
    logic signed [WIDTH-1:0] lim;
    if (sum[WIDTH-1]) lim = {1'b0, {(WIDTH-1){1'b1}}};
    else              lim = {1'b1, {(WIDTH-1){1'b0}}};
    return lim;
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          op_d    = op_t'(bus.op_i);
          data_d  = bus.data_i;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = HOLD;
        case (op_q)
          OP_LOAD: begin
            acc_d   = data_q;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end
          OP_ADD, OP_SUB: begin
`ifdef SATURATE_EN
            acc_d = bus.ovf_i ? $unsigned(sat_value(bus.sum_i)) : bus.sum_i;
`else
            acc_d = bus.sum_i;
`endif
            carry_d  = bus.carry_i;
            ovf_d    = bus.ovf_i;
            sticky_d = sticky_q | bus.ovf_i;
          end
          default: begin
            acc_d    = '0;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            sticky_d = 1'b0;
          end
        endcase
      end
      HOLD: begin
        // Result stays frozen until the sink takes it.
        if (bus.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= OP_LOAD;
      data_q   <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.in_ready_o   = (state_q == IDLE);
  assign bus.out_valid_o  = (state_q == HOLD);
  assign bus.a_o          = acc_q;
  assign bus.b_o          = data_q;
  assign bus.add_sub_o    = (state_q == EXEC) && (op_q == OP_SUB);
  assign bus.acc_o        = acc_q;
  assign bus.carry_o      = carry_q;
  assign bus.ovf_o        = ovf_q;
  assign bus.zero_o       = (acc_q == '0);
  assign bus.neg_o        = acc_q[WIDTH-1];
  assign bus.sticky_ovf_o = sticky_q;

endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// tb_addsub_acc_ctrl
//   Directed bench for addsub_acc_ctrl: a table of command vectors with
//   hand-computed results, plus hand-written backpressure and reset
//   sequences. A behavioural model of the external adder closes the loop.
//   Honours SATURATE_EN for the overflow expectations.
module tb_addsub_acc_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  addsub_acc_if #(.WIDTH(W)) bus();

  addsub_acc_ctrl #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External adder: A + B, or A + ~B + 1 when subtracting.
  logic [W-1:0] b_eff;
  logic [W:0]   ext;
  always_comb begin
    b_eff       = bus.add_sub_o ? ~bus.b_o : bus.b_o;
    ext         = {1'b0, bus.a_o} + {1'b0, b_eff} + {{W{1'b0}}, bus.add_sub_o};
    bus.sum_i   = ext[W-1:0];
    bus.carry_i = ext[W];
    bus.ovf_i   = (bus.a_o[W-1] == b_eff[W-1]) && (ext[W-1] != bus.a_o[W-1]);
  end

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] data;
    logic [W-1:0] acc;
    logic         c;
    logic         o;
    logic         s;
    logic         z;
    logic         n;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE (waiting a bounded time for ready) and
  // return one cycle into HOLD.
  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] d);
    int n;
    n = 0;
    while (!bus.in_ready_o && n < 20) begin
      step();
      n++;
    end
    check("cmd_ready", 32'(bus.in_ready_o), 32'd1);
    bus.op_i       = op;
    bus.data_i     = d;
    bus.in_valid_i = 1'b1;
    step();
    bus.in_valid_i = 1'b0;
    check("exec_valid",  32'(bus.out_valid_o), 32'd0);
    check("exec_addsub", 32'(bus.add_sub_o), 32'(op == 2'b10));
    check("exec_b",      32'(bus.b_o), 32'(d));
    step();
    check("hold_valid",  32'(bus.out_valid_o), 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] acc, input logic c,
                           input logic o, input logic s, input logic z, input logic n);
    check({tag, "_acc"},    32'(bus.acc_o), 32'(acc));
    check({tag, "_carry"},  32'(bus.carry_o), 32'(c));
    check({tag, "_ovf"},    32'(bus.ovf_o), 32'(o));
    check({tag, "_sticky"}, 32'(bus.sticky_ovf_o), 32'(s));
    check({tag, "_zero"},   32'(bus.zero_o), 32'(z));
    check({tag, "_neg"},    32'(bus.neg_o), 32'(n));
  endtask

  initial begin
    //          op     data   acc    c     o     s     z     n
    vecs[0] = '{2'b00, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b01, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'b00, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'b10, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{2'b00, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{2'b00, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef SATURATE_EN
    vecs[7] = '{2'b01, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{2'b01, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    vecs[7] = '{2'b01, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{2'b01, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    vecs[9] = '{2'b11, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst             = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.op_i        = 2'b00;
    bus.data_i      = '0;
    bus.out_ready_i = 1'b1;
    step();
    step();
    check("rst_in_ready",  32'(bus.in_ready_o), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_addsub",    32'(bus.add_sub_o), 32'd0);
    check_res("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      do_cmd(vecs[i].op, vecs[i].data);
      check_res($sformatf("v%0d", i), vecs[i].acc, vecs[i].c, vecs[i].o,
                vecs[i].s, vecs[i].z, vecs[i].n);
    end
    step();

    // Backpressure: HOLD stalled 5 cycles while a new command waits.
    bus.out_ready_i = 1'b0;
    do_cmd(2'b00, 8'h42);
    bus.op_i       = 2'b01;
    bus.data_i     = 8'h11;
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.out_valid_o), 32'd1);
      check("bp_ready", 32'(bus.in_ready_o), 32'd0);
      check("bp_acc",   32'(bus.acc_o), 32'h42);
      step();
    end
    bus.out_ready_i = 1'b1;
    check("rel_valid", 32'(bus.out_valid_o), 32'd1);
    check("rel_ready", 32'(bus.in_ready_o), 32'd0);
    step();
    check("idle_ready", 32'(bus.in_ready_o), 32'd1);
    check("idle_valid", 32'(bus.out_valid_o), 32'd0);
    check("idle_acc",   32'(bus.acc_o), 32'h42);
    step();
    bus.in_valid_i = 1'b0;
    check("late_exec_ready", 32'(bus.in_ready_o), 32'd0);
    check("late_exec_b",     32'(bus.b_o), 32'h11);
    step();
    check("late_valid", 32'(bus.out_valid_o), 32'd1);
    check_res("late", 8'h53, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Reset during EXEC of ADD 0x10 on acc 0x20, with sticky already set.
    do_cmd(2'b00, 8'h7F);
    step();
    do_cmd(2'b01, 8'h01);
    check("pre_sticky", 32'(bus.sticky_ovf_o), 32'd1);
    step();
    do_cmd(2'b00, 8'h20);
    check("pre_acc", 32'(bus.acc_o), 32'h20);
    step();
    bus.op_i       = 2'b01;
    bus.data_i     = 8'h10;
    bus.in_valid_i = 1'b1;
    step();
    bus.in_valid_i = 1'b0;
    check("rx_exec_a", 32'(bus.a_o), 32'h20);
    rst = 1'b1;
    step();
    check("rx_ready", 32'(bus.in_ready_o), 32'd1);
    check("rx_valid", 32'(bus.out_valid_o), 32'd0);
    check_res("rx", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    step();
    check("rx_after_valid", 32'(bus.out_valid_o), 32'd0);
    check("rx_after_acc",   32'(bus.acc_o), 32'h00);
    check("rx_after_ready", 32'(bus.in_ready_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
